// File: rtl/exe_stage_pkg.sv
// Shared EXE-stage definitions: bus widths, ALU op bits,
// the ID->EXE and EXE->MEM payload layouts and source-select helpers.
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 136;
  localparam int ES_TO_MS_BUS_WD = 71;
  localparam int ALU_OP_WD       = 12;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SLT  = 2;
  localparam int OP_SLTU = 3;
  localparam int OP_AND  = 4;
  localparam int OP_NOR  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_XOR  = 7;
  localparam int OP_SLL  = 8;
  localparam int OP_SRL  = 9;
  localparam int OP_SRA  = 10;
  localparam int OP_LUI  = 11;

  typedef struct packed {
    logic [ALU_OP_WD-1:0] alu_op;
    logic        load_op;
    logic        src1_is_sa;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        src2_is_8;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [15:0] imm;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic [31:0] pc;
  } id_ex_t;

  typedef struct packed {
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } ex_mem_t;

  function automatic logic [31:0] sel_src1(input id_ex_t p);
    logic [31:0] v;
    if (p.src1_is_sa)
      v = {27'b0, p.imm[10:6]};
    else if (p.src1_is_pc)
      v = p.pc;
    else
      v = p.rs_value;
    return v;
  endfunction

  function automatic logic [31:0] sel_src2(input id_ex_t p);
    logic [31:0] v;
    if (p.src2_is_imm)
      v = {{16{p.imm[15]}}, p.imm};
    else if (p.src2_is_8)
      v = 32'd8;
    else
      v = p.rt_value;
    return v;
  endfunction

endpackage

// File: rtl/exe_stage_alu.sv
// One-hot ALU for the EXE stage.
// Ports: alu_op[11:0], src1, src2 in; result out (0 when alu_op is 0).
module alu
  import exe_stage_pkg::*;
(
  input  logic [ALU_OP_WD-1:0] alu_op,
  input  logic [31:0]          src1,
  input  logic [31:0]          src2,
  output logic [31:0]          result
);

  logic [4:0] sh;
  logic       lt_s;
  logic       lt_u;

  assign sh   = src1[4:0];
  assign lt_s = $signed(src1) < $signed(src2);
  assign lt_u = src1 < src2;

  always_comb begin
    result = '0;
    unique case (1'b1)
      alu_op[OP_ADD]:  result = src1 + src2;
      alu_op[OP_SUB]:  result = src1 - src2;
      alu_op[OP_SLT]:  result = {31'b0, lt_s};
      alu_op[OP_SLTU]: result = {31'b0, lt_u};
      alu_op[OP_AND]:  result = src1 & src2;
      alu_op[OP_NOR]:  result = ~(src1 | src2);
      alu_op[OP_OR]:   result = src1 | src2;
      alu_op[OP_XOR]:  result = src1 ^ src2;
      alu_op[OP_SLL]:  result = src2 << sh;
      alu_op[OP_SRL]:  result = src2 >> sh;
      alu_op[OP_SRA]:  result = $unsigned($signed(src2) >>> sh);
      alu_op[OP_LUI]:  result = {src2[15:0], 16'b0};
      default:         result = '0;
    endcase
  end

endmodule

// File: rtl/exe_stage.sv
// Single-cycle EXE pipeline stage: latches the ID payload, runs the ALU,
// drives the data SRAM request and forwards results to MEM.
// Ports: clk, reset (sync, active-high); ID side ds_to_es_valid/bus,
// es_allowin; MEM side es_to_ms_valid/bus, ms_allowin; data_sram_*.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_wen,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  logic        es_valid;
  logic        es_ready_go;
  id_ex_t      es_bus_r;
  ex_mem_t     es_out;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] alu_result;

  assign es_ready_go    = 1'b1;
  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;

  always_ff @(posedge clk) begin
    if (reset)
      es_valid <= 1'b0;
    else if (es_allowin)
      es_valid <= ds_to_es_valid;
  end

  always_ff @(posedge clk) begin
    if (reset)
      es_bus_r <= '0;
    else if (ds_to_es_valid && es_allowin)
      es_bus_r <= id_ex_t'(ds_to_es_bus);
  end

  assign src1 = sel_src1(es_bus_r);
  assign src2 = sel_src2(es_bus_r);

  alu u_alu (
    .alu_op (es_bus_r.alu_op),
    .src1   (src1),
    .src2   (src2),
    .result (alu_result)
  );

  // gr_we is masked by es_valid so a bubble never looks like a
  // pending register write to ID's bypass/stall logic.
  always_comb begin
    es_out              = '0;
    es_out.res_from_mem = es_bus_r.load_op;
    es_out.gr_we        = es_bus_r.gr_we && es_valid;
    es_out.dest         = es_bus_r.dest;
    es_out.alu_result   = alu_result;
    es_out.pc           = es_bus_r.pc;
  end

  assign es_to_ms_bus = es_out;

  assign data_sram_en    = es_valid
                         && (es_bus_r.load_op || es_bus_r.mem_we);
  assign data_sram_wen   = {4{es_valid && es_bus_r.mem_we}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = es_bus_r.rt_value;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases then random traffic
// against an instruction-level reference model.
module tb_exe_stage;

  logic         clk;
  logic         reset;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [135:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          op;
    logic        load;
    logic        sa;
    logic        ispc;
    logic        simm;
    logic        s8;
    logic        gwe;
    logic        mwe;
    logic [4:0]  dest;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pc;
  } inst_t;

  logic  mv;
  inst_t mp;

  exe_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ms_allowin      (ms_allowin),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic inst_t blank();
    inst_t i;
    i.op = -1; i.load = 0; i.sa = 0; i.ispc = 0;
    i.simm = 0; i.s8 = 0; i.gwe = 0; i.mwe = 0;
    i.dest = 0; i.imm = 0; i.rs = 0; i.rt = 0; i.pc = 0;
    return i;
  endfunction

  function automatic logic [135:0] pack(input inst_t i);
    logic [11:0] ob;
    ob = 12'd0;
    if (i.op >= 0 && i.op < 12) ob[i.op] = 1'b1;
    return {ob, i.load, i.sa, i.ispc, i.simm, i.s8, i.gwe,
            i.mwe, i.dest, i.imm, i.rs, i.rt, i.pc};
  endfunction

  function automatic logic [31:0] ref_res(input inst_t i);
    logic [31:0] a;
    logic [31:0] b;
    int          s;
    longint      sb;
    a = i.sa ? {27'b0, i.imm[10:6]} : (i.ispc ? i.pc : i.rs);
    b = i.simm ? {{16{i.imm[15]}}, i.imm} : (i.s8 ? 32'd8 : i.rt);
    s = int'(a[4:0]);
    sb = longint'($signed(b));
    case (i.op)
      0:  return a + b;
      1:  return a - b;
      2:  return (longint'($signed(a)) < sb) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return b << s;
      9:  return b >> s;
      10: return 32'(sb / (longint'(1) << s)
               - ((sb < 0 && (sb % (longint'(1) << s)) != 0) ? 1 : 0));
      11: return {b[15:0], 16'h0000};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [70:0] got,
                       input logic [70:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] r;
    r = ref_res(mp);
    check("valid", 71'(es_to_ms_valid), 71'(mv));
    check("bus", es_to_ms_bus,
          {mp.load, mp.gwe & mv, mp.dest, r, mp.pc});
    check("sram_en", 71'(data_sram_en), 71'(mv & (mp.load | mp.mwe)));
    check("sram_wen", 71'(data_sram_wen), 71'({4{mv & mp.mwe}}));
    check("sram_addr", 71'(data_sram_addr), 71'(r));
    check("sram_wdata", 71'(data_sram_wdata), 71'(mp.rt));
  endtask

  task automatic cyc(input logic rst, input logic dv, input inst_t di,
                     input logic msa);
    logic allow;
    reset = rst;
    ds_to_es_valid = dv;
    ds_to_es_bus = pack(di);
    ms_allowin = msa;
    #1;
    allow = !mv || msa;
    if (!rst) check("allowin", 71'(es_allowin), 71'(allow));
    @(posedge clk);
    if (rst) begin
      mv = 1'b0;
      mp = blank();
    end else if (allow) begin
      mv = dv;
      if (dv) mp = di;
    end
    #1;
    check_outputs();
  endtask

  function automatic inst_t rnd_inst();
    inst_t i;
    i.op   = int'($urandom_range(0, 12));
    i.load = 1'($urandom);
    i.sa   = ($urandom_range(0, 3) == 0);
    i.ispc = ($urandom_range(0, 3) == 0);
    i.simm = ($urandom_range(0, 2) == 0);
    i.s8   = ($urandom_range(0, 3) == 0);
    i.gwe  = 1'($urandom);
    i.mwe  = 1'($urandom);
    i.dest = 5'($urandom);
    i.imm  = 16'($urandom);
    i.rs   = $urandom;
    i.rt   = $urandom;
    i.pc   = $urandom;
    return i;
  endfunction

  initial begin
    inst_t i;
    inst_t nx;
    mv = 1'b0;
    mp = blank();
    reset = 1'b1;
    ms_allowin = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus = '0;

    cyc(1, 0, blank(), 1);
    cyc(1, 0, blank(), 1);
    check("rst_bus_zero", es_to_ms_bus, 71'd0);
    check("rst_allowin", 71'(es_allowin), 71'd1);

    // addu overflow wraps
    i = blank(); i.op = 0; i.rs = 32'h7FFFFFFF; i.rt = 1;
    i.gwe = 1; i.dest = 5'd9; i.pc = 32'h00400000;
    cyc(0, 1, i, 1);
    check("add_res", 71'(es_to_ms_bus[63:32]), 71'(32'h80000000));
    check("add_valid", 71'(es_to_ms_valid), 71'd1);

    // sw with negative offset
    i = blank(); i.op = 0; i.simm = 1; i.imm = 16'hFFFC;
    i.rs = 32'h1000; i.rt = 32'hDEADBEEF; i.mwe = 1; i.pc = 32'h00400004;
    cyc(0, 1, i, 1);
    check("sw_addr", 71'(data_sram_addr), 71'(32'h00000FFC));
    check("sw_wen", 71'(data_sram_wen), 71'(4'hF));
    check("sw_wdata", 71'(data_sram_wdata), 71'(32'hDEADBEEF));

    // load held under back-pressure; the next one waits
    i = blank(); i.op = 0; i.simm = 1; i.imm = 16'h0010;
    i.rs = 32'h2000; i.load = 1; i.gwe = 1; i.dest = 5'd3;
    i.pc = 32'h00400008;
    cyc(0, 1, i, 1);
    nx = blank(); nx.op = 6; nx.rs = 32'hF0; nx.rt = 32'h0F;
    nx.gwe = 1; nx.dest = 5'd4; nx.pc = 32'h0040000C;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, nx, 0);
      check("stall_addr", 71'(data_sram_addr), 71'(32'h00002010));
    end
    cyc(0, 1, nx, 1);
    check("resume_res", 71'(es_to_ms_bus[63:32]), 71'(32'hFF));

    // jal link value
    i = blank(); i.op = 0; i.ispc = 1; i.s8 = 1; i.pc = 32'h00400010;
    i.gwe = 1; i.dest = 5'd31;
    cyc(0, 1, i, 1);
    check("jal_res", 71'(es_to_ms_bus[63:32]), 71'(32'h00400018));

    // sra by shamt 4
    i = blank(); i.op = 10; i.sa = 1; i.imm = 16'h0100;
    i.rt = 32'h80000000; i.gwe = 1; i.dest = 5'd5;
    cyc(0, 1, i, 1);
    check("sra_res", 71'(es_to_ms_bus[63:32]), 71'(32'hF8000000));

    // lui
    i = blank(); i.op = 11; i.simm = 1; i.imm = 16'h1234;
    i.gwe = 1; i.dest = 5'd5;
    cyc(0, 1, i, 1);
    check("lui_res", 71'(es_to_ms_bus[63:32]), 71'(32'h12340000));

    // bubble with stale gr_we=1, dest=5
    cyc(0, 0, i, 1);
    check("bubble_gwe", 71'(es_to_ms_bus[69]), 71'd0);
    check("bubble_en", 71'(data_sram_en), 71'd0);

    // reset while a store is stalled
    i = blank(); i.op = 0; i.rs = 32'h40; i.rt = 32'h55; i.mwe = 1;
    cyc(0, 1, i, 1);
    cyc(0, 0, blank(), 0);
    cyc(1, 0, blank(), 0);
    check("rst_stall_wen", 71'(data_sram_wen), 71'd0);
    check("rst_stall_valid", 71'(es_to_ms_valid), 71'd0);
    cyc(0, 0, blank(), 0);

    // full-rate streaming
    for (int k = 0; k < 20; k++)
      cyc(0, 1, rnd_inst(), 1);

    // random traffic
    for (int k = 0; k < 600; k++)
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
          rnd_inst(), ($urandom_range(0, 9) < 7));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
